// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: FSM encoding,
// port indices and the legal wait-cycle range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    localparam int WAIT_CYC_MIN = 1;
    localparam int WAIT_CYC_MAX = 15;

    // Counter preload for a given access length; out-of-range values are clamped.
    function automatic logic [3:0] wait_cyc_load(input int w);
        if (w < WAIT_CYC_MIN) return 4'd0;
        if (w > WAIT_CYC_MAX) return 4'(WAIT_CYC_MAX - 1);
        return 4'(w - 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_wait_state_counter.sv
// Loadable 4-bit down-counter with a zero flag; times the RAM access window.
module wait_state_counter (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port MOV/RW/MOC arbiter in front of the single-port RAM.
// Define ARB_RR_EN for round-robin; otherwise the data port has fixed priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MOV0,
    input  logic              RW0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Din0,
    output logic              MOC0,
    input  logic              MOV1,
    input  logic              RW1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Din1,
    output logic              MOC1,
    output logic [DATA_W-1:0] Dout,
    output logic [1:0]        Grant,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] CNT_LOAD = wait_cyc_load(WAIT_CYC);

    arb_state_t        state_q;
    logic [1:0]        grant_q;
    logic              moc0_q, moc1_q;
    logic              ram_en_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] dout_q;

    logic any_req;
    logic winner_d;
    logic granted_mov;
    logic cnt_zero;
    logic start;

    assign any_req     = MOV0 | MOV1;
    assign start       = (state_q == IDLE) && any_req;
    assign granted_mov = grant_q[1] ? MOV1 : MOV0;

`ifdef ARB_RR_EN
    logic rr_q;

    always_comb begin
        winner_d = MOV1 ? PORT_DATA : PORT_IF;
        if (MOV0 && MOV1) winner_d = rr_q;
    end

    // Point at the port that lost (or did not ask) so it wins the next tie.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            rr_q <= PORT_IF;
        end else if (start) begin
            rr_q <= ~winner_d;
        end
    end
`else
    always_comb begin
        winner_d = MOV1 ? PORT_DATA : PORT_IF;
    end
`endif

    wait_state_counter u_wait_cnt (
        .clk_i      (Clk),
        .clr_i      (Clr),
        .load_i     (start),
        .load_val_i (CNT_LOAD),
        .dec_i      (state_q == ACCESS),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            moc0_q      <= 1'b0;
            moc1_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            dout_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q     <= (winner_d == PORT_DATA) ? 2'b10 : 2'b01;
                        ram_addr_q  <= (winner_d == PORT_DATA) ? Addr1 : Addr0;
                        ram_wdata_q <= (winner_d == PORT_DATA) ? Din1 : Din0;
                        ram_we_q    <= (winner_d == PORT_DATA) ? ~RW1 : ~RW0;
                        ram_en_q    <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        // ram_we_q still holds the latched direction here.
                        if (!ram_we_q) dout_q <= ram_rdata;
                        ram_en_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        moc0_q   <= grant_q[0];
                        moc1_q   <= grant_q[1];
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (!granted_mov) begin
                        grant_q <= 2'b00;
                        moc0_q  <= 1'b0;
                        moc1_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MOC0      = moc0_q;
    assign MOC1      = moc1_q;
    assign Grant     = grant_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign Dout      = dout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model
// of the grant order, access window, MOC handshake and read-data capture.
module tb_mem_bus_arbiter;

    localparam int W = 2;

    logic        Clk, Clr;
    logic        MOV0, RW0, MOV1, RW1;
    logic [31:0] Addr0, Din0, Addr1, Din1;
    logic        MOC0, MOC1;
    logic [31:0] Dout;
    logic [1:0]  Grant;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0]  moc;

    assign moc = {MOC1, MOC0};

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(W)) dut (
        .Clk(Clk), .Clr(Clr),
        .MOV0(MOV0), .RW0(RW0), .Addr0(Addr0), .Din0(Din0), .MOC0(MOC0),
        .MOV1(MOV1), .RW1(RW1), .Addr1(Addr1), .Din1(Din1), .MOC1(MOC1),
        .Dout(Dout), .Grant(Grant),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    bit          mov_r [2];
    bit          rw_r  [2];
    logic [31:0] addr_r[2];
    logic [31:0] din_r [2];
    logic [31:0] dout_exp;
`ifdef ARB_RR_EN
    int          rr_exp;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drive();
        MOV0 = mov_r[0]; RW0 = rw_r[0]; Addr0 = addr_r[0]; Din0 = din_r[0];
        MOV1 = mov_r[1]; RW1 = rw_r[1]; Addr1 = addr_r[1]; Din1 = din_r[1];
    endtask

    task automatic new_req(input int p);
        mov_r[p]  = 1'b1;
        rw_r[p]   = 1'($urandom_range(0, 1));
        addr_r[p] = $urandom;
        din_r[p]  = $urandom;
    endtask

    // One complete transaction, starting and ending at a negedge with the DUT idle.
    task automatic txn(input int hold, input bit drop_early, input bit raise_other,
                       input bit fix_rd, input logic [31:0] fix_val);
        int w, o;
        logic [1:0]  oh;
        logic [31:0] rd;
        rd = 32'h0;
        if (mov_r[0] && mov_r[1]) begin
`ifdef ARB_RR_EN
            w = rr_exp;
`else
            w = 1;
`endif
        end else begin
            w = mov_r[1] ? 1 : 0;
        end
        o  = 1 - w;
        oh = (w == 1) ? 2'b10 : 2'b01;
`ifdef ARB_RR_EN
        rr_exp = o;
`endif
        drive();
        tick();
        for (int k = 0; k < W; k++) begin
            if (k == 0 && drop_early) begin
                mov_r[w] = 1'b0;
                drive();
            end
            if (k == 0 && raise_other && !mov_r[o]) begin
                new_req(o);
                drive();
            end
            rd = fix_rd ? fix_val : $urandom;
            ram_rdata = rd;
            chk("acc_grant", Grant, oh);
            chk("acc_en", ram_en, 1);
            chk("acc_we", ram_we, !rw_r[w]);
            chk("acc_addr", ram_addr, addr_r[w]);
            chk("acc_wdata", ram_wdata, din_r[w]);
            chk("acc_moc", moc, 0);
            tick();
        end
        if (rw_r[w]) dout_exp = rd;
        ram_rdata = $urandom;
        chk("done_moc", moc, oh);
        chk("done_en", ram_en, 0);
        chk("done_grant", Grant, oh);
        chk("done_dout", Dout, dout_exp);
        if (!drop_early) begin
            for (int h = 0; h < hold; h++) begin
                ram_rdata = $urandom;
                tick();
                chk("hold_moc", moc, oh);
                chk("hold_grant", Grant, oh);
                chk("hold_dout", Dout, dout_exp);
            end
        end
        mov_r[w] = 1'b0;
        drive();
        tick();
        chk("rel_moc", moc, 0);
        chk("rel_grant", Grant, 0);
        chk("rel_en", ram_en, 0);
        chk("rel_dout", Dout, dout_exp);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            mov_r[p] = 0; rw_r[p] = 0; addr_r[p] = '0; din_r[p] = '0;
        end
        dout_exp  = '0;
`ifdef ARB_RR_EN
        rr_exp    = 0;
`endif
        ram_rdata = '0;
        drive();
        Clr = 1'b1;
        tick();
        tick();
        chk("rst_grant", Grant, 0);
        chk("rst_moc", moc, 0);
        chk("rst_en", ram_en, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_dout", Dout, 0);

        // Clr must beat a pending request.
        mov_r[0] = 1; drive();
        tick();
        chk("clr_wins", Grant, 0);
        mov_r[0] = 0; drive();
        Clr = 1'b0;

        mov_r[0] = 1; rw_r[0] = 1; addr_r[0] = 32'h10; din_r[0] = 32'h0;
        txn(0, 0, 0, 1, 32'hDEADBEEF);
        chk("rd_value", Dout, 32'hDEADBEEF);

        mov_r[1] = 1; rw_r[1] = 0; addr_r[1] = 32'h20; din_r[1] = 32'h12345678;
        txn(1, 0, 0, 0, 32'h0);

        // Simultaneous requests with both ports re-asserting.
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 2; p++) if (!mov_r[p]) new_req(p);
            txn(0, 0, 0, 0, 32'h0);
        end
        while (mov_r[0] || mov_r[1]) txn(0, 0, 0, 0, 32'h0);

        // Held MOV0 keeps ownership while MOV1 waits.
        new_req(0);
        txn(3, 0, 1, 0, 32'h0);
        txn(0, 0, 0, 0, 32'h0);

        // Clr during ACCESS aborts without MOC; held MOV0 is then re-granted.
        new_req(0);
        rw_r[0] = 1;
        drive();
        tick();
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        dout_exp = '0;
`ifdef ARB_RR_EN
        rr_exp = 0;
`endif
        chk("abort_grant", Grant, 0);
        chk("abort_en", ram_en, 0);
        chk("abort_moc", moc, 0);
        chk("abort_dout", Dout, 0);
        txn(0, 0, 0, 0, 32'h0);

        // MOV dropped during ACCESS: single-cycle MOC.
        new_req(1);
        txn(0, 1, 0, 0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++)
                if (!mov_r[p] && $urandom_range(0, 1) == 1) new_req(p);
            if (!mov_r[0] && !mov_r[1]) new_req(int'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0)
                txn(0, 1, 0, 0, 32'h0);
            else
                txn(int'($urandom_range(0, 2)), 0, 0, 0, 32'h0);
        end
        while (mov_r[0] || mov_r[1]) txn(0, 0, 0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single-port instruction/data RAM between the control unit's instruction-fetch path (port 0, MAR/IR load path) and its data-access path (port 1, load/store MDR path). Each port uses the codebase MOV/RW/MOC handshake. The arbiter grants one requester at a time, drives the RAM for a fixed number of wait cycles, and returns MOC with read data. It sits between the control-unit datapath and the RAM model.

## Interface
Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- WAIT_CYC, 2: RAM access cycles per transaction, legal range 1..15.

Ports:
- Clk  in  1  single clock; all state changes on the rising edge.
- Clr  in  1  reset; synchronous, active-high.
- MOV0  in  1  port 0 (fetch) request.
- RW0  in  1  port 0 direction: 1 = read, 0 = write.
- Addr0  in  ADDR_W  port 0 address.
- Din0  in  DATA_W  port 0 write data.
- MOC0  out  1  port 0 operation complete.
- MOV1, RW1, Addr1, Din1, MOC1: the same signals for port 1 (data).
- Dout  out  DATA_W  read data for the granted port; valid while its MOC is high.
- Grant  out  2  one-hot current owner: bit0 = port 0, bit1 = port 1, 00 = none.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid while ram_en is high.

## Operation
States: IDLE, ACCESS, DONE.

- **IDLE**
  - If neither MOV is high: stay in IDLE.
  - If one or both MOV are high: select the winner (see Configuration).
  - Latch the winner's Addr, Din and RW into internal registers; requesters only need stable values at that edge.
  - Set Grant, load cnt = WAIT_CYC-1, go to ACCESS.
- **ACCESS**
  - ram_en = 1.
  - ram_we = ~latched RW.
  - ram_addr and ram_wdata come from the latched registers.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: capture Dout <= ram_rdata (reads only; writes leave Dout unchanged) and go to DONE.
- **DONE**
  - ram_en = 0.
  - MOC of the granted port = 1; MOC of the other port = 0.
  - When the granted port's MOV is sampled low: Grant <= 00, go to IDLE.
- Four-phase handshake: a requester holds MOV high until it sees MOC high, then drops MOV. MOC falls on the edge after MOV is sampled low.
- The non-granted port's MOV is ignored and may stay high; it is served on a later IDLE.
- Reset values: state = IDLE, Grant = 00, MOC0 = MOC1 = 0, ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, Dout = 0, cnt = 0, rr_ptr = 0.
- Clr high in any state, including mid-ACCESS, aborts the transaction with no MOC pulse. Clr wins over every other event on the same edge.
- A MOV that drops during ACCESS (protocol violation): the access still completes. DONE then exits on the next edge because MOV is already low, so MOC is high for one cycle.

## Timing
- Request latency: MOV sampled high in IDLE at edge E0 makes MOC high after edge E0+WAIT_CYC. With the default WAIT_CYC = 2, that is 2 cycles.
- ram_en is high for exactly WAIT_CYC cycles per transaction.
- Release: MOV sampled low at edge E1 makes MOC low and state IDLE after E1.
- Earliest next grant: edge E1+1.
- Minimum cycles per transaction: WAIT_CYC+2.
- MOC, Grant and ram_* are decoded from registered state and latched fields only, with no combinational path from MOV. Dout is registered.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, rr_ptr selects the winner.
  - rr_ptr resets to 0 (fetch port preferred first).
  - On every grant, rr_ptr <= index of the other port.
  - A single requester always wins regardless of rr_ptr.
- ARB_RR_EN undefined: fixed priority, port 1 (data) always beats port 0. No rr_ptr register exists.

## Structure
- Shared package mem_arb_pkg:
  - state encoding IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - port index constants PORT_IF = 0, PORT_DATA = 1;
  - the WAIT_CYC legality range.
- One sub-module, wait_state_counter: loadable 4-bit down-counter with a zero flag, used for cnt.

## Test plan
- Single read: MOV0 = 1, RW0 = 1, Addr0 = 0x10, ram_rdata = 0xDEADBEEF -> ram_en high 2 cycles, ram_we = 0; MOC0 high after 2 edges with Dout = 0xDEADBEEF; MOC0 falls the edge after MOV0 drops.
- Single write: MOV1 = 1, RW1 = 0, Addr1 = 0x20, Din1 = 0x12345678 -> ram_we = 1, ram_addr = 0x20, ram_wdata = 0x12345678 for 2 cycles; MOC1 pulse; Dout unchanged.
- Simultaneous requests, both ports holding MOV:
  - With ARB_RR_EN: grants alternate 0, 1, 0, 1.
  - Without ARB_RR_EN: port 1 is granted every time until MOV1 stays low, then port 0.
- Clr pulsed while ACCESS has cnt = 1 -> next cycle Grant = 00, ram_en = 0, no MOC; a held MOV0 is re-granted from IDLE.
- MOV0 held high after MOC0 -> stays in DONE with MOC0 high; a pending MOV1 is not granted until MOV0 drops.
- WAIT_CYC = 1 build -> MOC asserted 1 edge after request; back-to-back transactions take 3 cycles each.
